// File: rtl/z80_idx_mem_seq.sv
// Sequencer for Z80 indexed memory ops LD (IX/IY+d),r / LD r,(IX/IY+d) / LD (IX/IY+d),n.
// Latches operands, forms base+d, waits the address-calc delay, runs one handshaked memory cycle.
module z80_idx_mem_seq #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SIGN_EXT_D = 1,
  parameter int CALC_CYC   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        d,
  input  logic [DATA_W-1:0] src_data,
  input  logic [3:0]        dst_rnum,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              reg_wr,
  output logic [3:0]        reg_wnum,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_LD_R   = 2'b01;
  localparam logic [1:0] OP_ILL    = 2'b11;
  localparam logic [3:0] CALC_LOAD = 4'(CALC_CYC - 1);

  function automatic logic [ADDR_W-1:0] ext_d(input logic [7:0] disp);
    if (SIGN_EXT_D != 0) begin
      ext_d = {{(ADDR_W-8){disp[7]}}, disp};
    end else begin
      ext_d = {{(ADDR_W-8){1'b0}}, disp};
    end
  endfunction

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [1:0]        op_r;
  logic              accept_s, illegal_s;
  logic              busy_r, mem_rd_r, mem_wr_r, reg_wr_r, done_r, err_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r, reg_wdata_r;
  logic [3:0]        reg_wnum_r;

  // next-state, counter and request classification
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    illegal_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (op != OP_ILL)) begin
          accept_s    = 1'b1;
          cnt_nxt_s   = CALC_LOAD;
          state_nxt_s = ST_CALC;
        end else if (start) begin
          illegal_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_MEM;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register and operand latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      op_r        <= 2'b00;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      reg_wnum_r  <= 4'd0;
      reg_wdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        op_r        <= op;
        mem_addr_r  <= base + ext_d(d);
        mem_wdata_r <= src_data;
        reg_wnum_r  <= dst_rnum;
      end
      if ((state_r == ST_MEM) && mem_ready && (op_r == OP_LD_R)) begin
        reg_wdata_r <= mem_rdata;
      end
    end
  end

  // registered strobes decoded from the upcoming state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r   <= 1'b0;
      mem_rd_r <= 1'b0;
      mem_wr_r <= 1'b0;
      reg_wr_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      busy_r   <= (state_nxt_s != ST_IDLE);
      mem_rd_r <= (state_nxt_s == ST_MEM) && (op_r == OP_LD_R);
      mem_wr_r <= (state_nxt_s == ST_MEM) && (op_r != OP_LD_R);
      reg_wr_r <= (state_nxt_s == ST_DONE) && (op_r == OP_LD_R);
      done_r   <= (state_nxt_s == ST_DONE);
      err_r    <= illegal_s;
    end
  end

  assign busy      = busy_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_rd    = mem_rd_r;
  assign mem_wr    = mem_wr_r;
  assign reg_wr    = reg_wr_r;
  assign reg_wnum  = reg_wnum_r;
  assign reg_wdata = reg_wdata_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_z80_idx_mem_seq.sv
// Directed bench for z80_idx_mem_seq; a second instance with zero-extended d shares all inputs.
module tb_z80_idx_mem_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, mem_ready;
  logic [1:0]  op;
  logic [15:0] base;
  logic [7:0]  d, src_data, mem_rdata;
  logic [3:0]  dst_rnum;

  logic        busy, mem_rd, mem_wr, reg_wr, done, err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, reg_wdata;
  logic [3:0]  reg_wnum;

  logic        z_busy, z_mem_rd, z_mem_wr, z_reg_wr, z_done, z_err;
  logic [15:0] z_mem_addr;
  logic [7:0]  z_mem_wdata, z_reg_wdata;
  logic [3:0]  z_reg_wnum;

  int checks = 0;
  int errors = 0;

  z80_idx_mem_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .base(base), .d(d),
    .src_data(src_data), .dst_rnum(dst_rnum), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_wr(reg_wr), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata), .done(done), .err(err)
  );

  z80_idx_mem_seq #(.SIGN_EXT_D(0)) dut_z (
    .clk(clk), .reset(reset), .start(start), .op(op), .base(base), .d(d),
    .src_data(src_data), .dst_rnum(dst_rnum), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(z_busy), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr),
    .reg_wr(z_reg_wr), .reg_wnum(z_reg_wnum), .reg_wdata(z_reg_wdata), .done(z_done), .err(z_err)
  );

  task automatic step;
    @(negedge clk);
  endtask

  // Issue one request and record what the bus and register ports do until done.
  task automatic do_op(input logic [1:0] o, input logic [15:0] b, input logic [7:0] dd,
                       input logic [7:0] src, input logic [3:0] rn, input int waits, input bit inject,
                       output int lat, output int wr_cyc, output int rd_cyc,
                       output logic [15:0] addr_s, output logic [15:0] addr2_s, output bit stable,
                       output logic [7:0] wd_s, output int regwr_cnt, output logic [7:0] rwd_s,
                       output logic [3:0] rnum_s, output bit both);
    int wc;
    op = o; base = b; d = dd; src_data = src; dst_rnum = rn;
    start = 1'b1; mem_ready = 1'b0;
    lat = -1; wr_cyc = 0; rd_cyc = 0; addr_s = 16'hxxxx; addr2_s = 16'hxxxx; stable = 1'b1;
    wd_s = 8'hxx; regwr_cnt = 0; rwd_s = 8'hxx; rnum_s = 4'hx; both = 1'b0; wc = 0;
    for (int n = 1; n <= 60; n++) begin
      step;
      start = inject && (n == 2);
      if (mem_rd && mem_wr) both = 1'b1;
      if (mem_rd || mem_wr) begin
        if (wr_cyc + rd_cyc == 0) begin
          addr_s = mem_addr; addr2_s = z_mem_addr; wd_s = mem_wdata;
        end else if ((mem_addr !== addr_s) || (mem_wdata !== wd_s)) begin
          stable = 1'b0;
        end
        if (mem_wr) wr_cyc++; else rd_cyc++;
        wc++;
        mem_ready = (wc > waits);
      end else begin
        mem_ready = 1'b0;
      end
      if (reg_wr) begin
        regwr_cnt++; rwd_s = reg_wdata; rnum_s = reg_wnum;
      end
      if (done) begin
        lat = n;
        if (inject) start = 1'b1;
        break;
      end
    end
    step;
    start = 1'b0;
    if (reg_wr) regwr_cnt++;
    if (done) lat = -2;
  endtask

  int lat, wrc, rdc, rwc;
  logic [15:0] a1, a2;
  logic [7:0] wd, rwd;
  logic [3:0] rn;
  bit stb, both;

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 2'b00; base = 16'h0; d = 8'h0; src_data = 8'h0;
    dst_rnum = 4'h0; mem_rdata = 8'h0; mem_ready = 1'b0;
    repeat (3) step;
    checks++;
    if ({busy, mem_addr, mem_wdata, mem_rd, mem_wr, reg_wr, reg_wnum, reg_wdata, done, err} !== 42'd0) begin
      errors++; $display("FAIL reset_outputs: busy=%b addr=%h wdata=%h rd=%b wr=%b got nonzero, need all 0",
                         busy, mem_addr, mem_wdata, mem_rd, mem_wr);
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_store_r;
    do_op(2'b00, 16'h1000, 8'h05, 8'hA5, 4'h2, 0, 1'b0, lat, wrc, rdc, a1, a2, stb, wd, rwc, rwd, rn, both);
    checks++; if (lat !== 7) begin errors++; $display("FAIL store_latency: got %0d need 7", lat); end
    checks++; if (wrc !== 1 || rdc !== 0) begin errors++; $display("FAIL store_strobes: wr=%0d rd=%0d need 1/0", wrc, rdc); end
    checks++; if (a1 !== 16'h1005) begin errors++; $display("FAIL store_addr: got %h need 1005", a1); end
    checks++; if (wd !== 8'hA5) begin errors++; $display("FAIL store_wdata: got %h need a5", wd); end
    checks++; if (rwc !== 0) begin errors++; $display("FAIL store_reg_wr: got %0d pulses need 0", rwc); end
  endtask

  task automatic test_load_neg_d;
    mem_rdata = 8'h3C;
    do_op(2'b01, 16'h2000, 8'hFE, 8'h00, 4'h7, 0, 1'b0, lat, wrc, rdc, a1, a2, stb, wd, rwc, rwd, rn, both);
    checks++; if (lat !== 7) begin errors++; $display("FAIL load_latency: got %0d need 7", lat); end
    checks++; if (rdc !== 1 || wrc !== 0) begin errors++; $display("FAIL load_strobes: rd=%0d wr=%0d need 1/0", rdc, wrc); end
    checks++; if (a1 !== 16'h1FFE) begin errors++; $display("FAIL load_addr_sext: got %h need 1ffe", a1); end
    checks++; if (a2 !== 16'h20FE) begin errors++; $display("FAIL load_addr_zext: got %h need 20fe", a2); end
    checks++; if (rwc !== 1) begin errors++; $display("FAIL load_reg_wr: got %0d pulses need 1", rwc); end
    checks++; if (rwd !== 8'h3C || rn !== 4'h7) begin errors++; $display("FAIL load_reg_data: got %h/%h need 3c/7", rwd, rn); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL load_both_strobes: got %b need 0", both); end
  endtask

  task automatic test_wrap;
    do_op(2'b00, 16'hFFFF, 8'h01, 8'h11, 4'h0, 0, 1'b0, lat, wrc, rdc, a1, a2, stb, wd, rwc, rwd, rn, both);
    checks++; if (a2 !== 16'h0000) begin errors++; $display("FAIL wrap_zext: got %h need 0000", a2); end
    checks++; if (a1 !== 16'h0000) begin errors++; $display("FAIL wrap_sext: got %h need 0000", a1); end
  endtask

  task automatic test_wait_states;
    do_op(2'b10, 16'h3456, 8'h80, 8'h5A, 4'h0, 3, 1'b0, lat, wrc, rdc, a1, a2, stb, wd, rwc, rwd, rn, both);
    checks++; if (wrc !== 4 || rdc !== 0) begin errors++; $display("FAIL wait_wr_cycles: wr=%0d rd=%0d need 4/0", wrc, rdc); end
    checks++; if (stb !== 1'b1) begin errors++; $display("FAIL wait_addr_stable: got %b need 1", stb); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL wait_latency: got %0d need 10", lat); end
    checks++; if (a1 !== 16'h33D6 || a2 !== 16'h34D6) begin errors++; $display("FAIL wait_addr: got %h/%h need 33d6/34d6", a1, a2); end
    checks++; if (wd !== 8'h5A || rwc !== 0) begin errors++; $display("FAIL wait_data: got %h reg_wr=%0d need 5a/0", wd, rwc); end
  endtask

  task automatic test_ignored_starts;
    bit busy_seen;
    op = 2'b11; base = 16'hABCD; d = 8'h01; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_err: err=%b busy=%b need 1/0", err, busy); end
    checks++; if (mem_addr !== 16'h33D6) begin errors++; $display("FAIL illegal_no_latch: got %h need 33d6", mem_addr); end
    step;
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL illegal_pulse: err=%b busy=%b need 0/0", err, busy); end
    do_op(2'b00, 16'h4000, 8'h10, 8'h22, 4'h0, 0, 1'b1, lat, wrc, rdc, a1, a2, stb, wd, rwc, rwd, rn, both);
    checks++; if (lat !== 7 || wrc !== 1) begin errors++; $display("FAIL inject_op: lat=%0d wr=%0d need 7/1", lat, wrc); end
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (busy || mem_wr || done) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL inject_no_second_op: got %b need 0", busy_seen); end
  endtask

  task automatic test_reset_in_mem;
    bit seen;
    op = 2'b00; base = 16'h5000; d = 8'h00; src_data = 8'h77; start = 1'b1; mem_ready = 1'b0;
    step;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_wr) begin seen = 1'b1; break; end
      step;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_mem_reach: got %b need 1", seen); end
    reset = 1'b1;
    step;
    checks++;
    if ({busy, mem_addr, mem_wdata, mem_rd, mem_wr, reg_wr, reg_wnum, reg_wdata, done, err} !== 42'd0) begin
      errors++; $display("FAIL rst_mem_outputs: busy=%b addr=%h wdata=%h wr=%b rwdata=%h need all 0",
                         busy, mem_addr, mem_wdata, mem_wr, reg_wdata);
    end
    reset = 1'b0;
    step;
    mem_rdata = 8'h3C;
    do_op(2'b01, 16'h0100, 8'h02, 8'h00, 4'h4, 0, 1'b0, lat, wrc, rdc, a1, a2, stb, wd, rwc, rwd, rn, both);
    checks++; if (lat !== 7 || rdc !== 1) begin errors++; $display("FAIL post_rst_op: lat=%0d rd=%0d need 7/1", lat, rdc); end
    checks++; if (a1 !== 16'h0102 || rwd !== 8'h3C) begin errors++; $display("FAIL post_rst_data: addr=%h data=%h need 0102/3c", a1, rwd); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, need finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_store_r;
    test_load_neg_d;
    test_wrap;
    test_wait_states;
    test_ignored_starts;
    test_reset_in_mem;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
